// File: rtl/ifetch.sv
// Instruction fetch stage: program counter, imem req/ack port, small {word, pc} queue toward decode.
// Define IFETCH_PREFETCH_EN for a two-entry queue with back-to-back fetch; otherwise one entry.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ctl_pc_src,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [15:0] br_imm16,
    input  logic [31:0] br_reg,
    output logic [31:0] pc_link,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] ir_pc
);

    // state | meaning
    // IDLE  | no request outstanding; waits for a free queue slot or a redirect
    // REQ   | request to imem_addr outstanding; ack pushes into the queue
    // DROP  | stale request outstanding after a redirect; its data is discarded

`ifdef IFETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [1:0] DEPTH_C = 2'(DEPTH);
    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_next;
    logic [31:0] req_addr;
    logic [31:0] req_addr_next;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic [1:0]  wr_idx;
    logic [31:0] word_q [DEPTH];
    logic [31:0] pc_q   [DEPTH];

    logic        redirect;
    logic        push;
    logic        pop;
    logic        has_space;
    logic [31:0] imm_off;
    logic [31:0] target_imm;
    logic [31:0] target;
    logic [3:0]  unused_bits;

    assign pc_link    = ex_pc + 32'd4;
    assign imm_off    = {{14{br_imm16[15]}}, br_imm16, 2'b00};
    assign target_imm = pc_link + imm_off;
    assign redirect   = ex_valid && (ctl_pc_src == 2'b01 || ctl_pc_src == 2'b10);
    assign target     = (ctl_pc_src == 2'b10) ? {br_reg[31:2], 2'b00}
                                              : {target_imm[31:2], 2'b00};
    assign unused_bits = {br_reg[1:0], target_imm[1:0]};

    // A flush cancels both the pop and any push from this cycle.
    assign pop  = (count != 2'd0) && ir_ready && !redirect;
    assign push = (state == S_REQ) && imem_ack && !redirect;

    always_comb begin
        count_next = count;
        if (redirect) begin
            count_next = 2'd0;
        end else begin
            count_next = count + 2'(push) - 2'(pop);
        end
    end

    assign has_space = (count_next < DEPTH_C);
    assign wr_idx    = count - 2'(pop);

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_addr_next = req_addr;
        case (state)
            S_IDLE: begin
                if (redirect) begin
                    state_next    = S_REQ;
                    fetch_pc_next = target;
                    req_addr_next = target;
                end else if (has_space) begin
                    state_next    = S_REQ;
                    req_addr_next = fetch_pc;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    fetch_pc_next = target;
                    if (imem_ack) begin
                        state_next    = S_REQ;
                        req_addr_next = target;
                    end else begin
                        state_next = S_DROP;
                    end
                end else if (imem_ack) begin
                    fetch_pc_next = req_addr + 32'd4;
                    if (has_space) begin
                        state_next    = S_REQ;
                        req_addr_next = req_addr + 32'd4;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                // The stale word is thrown away; the newest target is fetched once it returns.
                if (redirect) begin
                    fetch_pc_next = target;
                end
                if (imem_ack) begin
                    state_next    = S_REQ;
                    req_addr_next = redirect ? target : fetch_pc;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC_W;
            req_addr <= RESET_PC_W;
            count    <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= 32'd0;
                pc_q[i]   <= 32'd0;
            end
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            req_addr <= req_addr_next;
            count    <= count_next;
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    word_q[i] <= word_q[i + 1];
                    pc_q[i]   <= pc_q[i + 1];
                end
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wr_idx == 2'(i)) begin
                        word_q[i] <= imem_rdata;
                        pc_q[i]   <= req_addr;
                    end
                end
            end
        end
    end

    assign imem_req  = (state == S_REQ) || (state == S_DROP);
    assign imem_addr = req_addr;
    assign ir_valid  = (count != 2'd0);
    assign ir        = word_q[0];
    assign ir_pc     = pc_q[0];

endmodule
